dro_bank: RTL

- Parametrised, clocked N-channel successor to the single destructive-readout (DRO) cell model.
- Each channel stores a set pulse until a shared readout strobe, then emits a one-cycle output pulse.
- Adds the following, none of which the single cell has:
  - runtime DRO/NDRO mode;
  - per-channel setup/hold violation detection, mirroring the SDF timing checks of the cell library;
  - a saturating violation counter.
- Sits between pulse-level stimulus generators and checkers in the cell-library regression benches, and is reusable as a storage stage in larger pulse-logic models.

---
 rtl/dro_pkg.sv | 33 +++
 rtl/dro_channel.sv | 108 ++++++++++
 rtl/dro_bank.sv | 89 ++++++++
 3 files changed

// File: rtl/dro_pkg.sv
// ============================================================================
// Module      : dro_pkg
// Description : Shared types and helpers for the DRO storage bank.
//               - dro_mode_e   : readout mode (destructive / non-destructive)
//               - chan_state_e : per-channel storage state
//               - cnt_width()  : width of the since_set / since_rd counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dro_pkg;

   typedef enum logic {
      DRO  = 1'b0,
      NDRO = 1'b1
   } dro_mode_e;

   typedef enum logic {
      EMPTY  = 1'b0,
      STORED = 1'b1
   } chan_state_e;

   // Both counters share one width, wide enough for the larger saturation
   // value: SETUP_CYC for since_set, HOLD_CYC+1 for since_rd.
   function automatic int cnt_width(input int setup_cyc, input int hold_cyc);
      int m;
      m = (setup_cyc > hold_cyc + 1) ? setup_cyc : hold_cyc + 1;
      return $clog2(m + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dro_channel.sv
// ============================================================================
// Module      : dro_channel
// Description : One DRO/NDRO storage channel with setup/hold violation checks.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               set        - set pulse for this channel
//               reset      - shared readout strobe
//               clr        - shared silent clear
//               mode_ndro  - 0 = destructive, 1 = non-destructive readout
//               out        - registered readout pulse
//               viol_setup - registered setup-violation pulse
//               viol_hold  - registered hold-violation pulse
//               viol_next  - combinational "violation next cycle" for counting
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dro_channel
   import dro_pkg::*;
#(
   parameter int SETUP_CYC = 3,
   parameter int HOLD_CYC  = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set,
   input  logic reset,
   input  logic clr,
   input  logic mode_ndro,
   output logic out,
   output logic viol_setup,
   output logic viol_hold,
   output logic viol_next
);

   localparam int            CW      = cnt_width(SETUP_CYC, HOLD_CYC);
   localparam logic [CW-1:0] SET_SAT = CW'(SETUP_CYC);
   localparam logic [CW-1:0] RD_SAT  = CW'(HOLD_CYC + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYC);
   localparam logic [CW-1:0] ONE     = CW'(1);

   chan_state_e   state, state_nxt;
   logic [CW-1:0] since_set, since_set_nxt;
   logic [CW-1:0] since_rd, since_rd_nxt;
   logic          out_nxt, vs_nxt, vh_nxt;
   logic          set_early, hold_win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         since_set  <= SET_SAT;
         since_rd   <= RD_SAT;
         out        <= 1'b0;
         viol_setup <= 1'b0;
         viol_hold  <= 1'b0;
      end else begin
         state      <= state_nxt;
         since_set  <= since_set_nxt;
         since_rd   <= since_rd_nxt;
         out        <= out_nxt;
         viol_setup <= vs_nxt;
         viol_hold  <= vh_nxt;
      end
   end

   always_comb begin
      // A set in the readout cycle itself counts as distance 0.
      set_early     = set | (since_set < SET_SAT);
      // since_rd is never below 1, so HOLD_CYC=0 makes this window empty.
      hold_win      = (since_rd <= HOLD_LIM);
      state_nxt     = state;
      since_set_nxt = (since_set < SET_SAT) ? since_set + ONE : since_set;
      since_rd_nxt  = (since_rd < RD_SAT) ? since_rd + ONE : since_rd;
      out_nxt       = 1'b0;
      vs_nxt        = 1'b0;
      vh_nxt        = 1'b0;

      if (reset) begin
         since_rd_nxt  = ONE;
         // The readout consumes (or loses) the pending set, so a later
         // readout does not re-flag the same set.
         since_set_nxt = SET_SAT;
         if (set_early) begin
            vs_nxt    = 1'b1;
            state_nxt = EMPTY;
         end else begin
            out_nxt   = (state == STORED);
            state_nxt = (state == STORED && dro_mode_e'(mode_ndro) == NDRO && !clr)
                        ? STORED : EMPTY;
         end
      end else begin
         if (set && hold_win) begin
            vh_nxt = 1'b1;
         end else if (set) begin
            state_nxt     = STORED;
            since_set_nxt = ONE;
         end
         if (clr) begin
            state_nxt = EMPTY;
         end
      end
   end

   assign viol_next = vs_nxt | vh_nxt;

endmodule

`default_nettype wire

// File: rtl/dro_bank.sv
// ============================================================================
// Module      : dro_bank
// Description : N-channel DRO/NDRO storage bank with per-channel setup/hold
//               violation pulses and a saturating violation counter.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               set        - per-channel set pulses [CHANNELS]
//               reset      - shared readout strobe
//               clr        - shared silent clear
//               mode_ndro  - 0 = destructive, 1 = non-destructive readout
//               out        - readout pulses [CHANNELS]
//               viol_setup - setup-violation pulses [CHANNELS]
//               viol_hold  - hold-violation pulses [CHANNELS]
//               viol_cnt   - saturating violation total [CNT_W]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dro_bank
   import dro_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int SETUP_CYC = 3,
   parameter int HOLD_CYC  = 2,
   parameter int CNT_W     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] set,
   input  logic                reset,
   input  logic                clr,
   input  logic                mode_ndro,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] viol_setup,
   output logic [CHANNELS-1:0] viol_hold,
   output logic [CNT_W-1:0]    viol_cnt
);

   localparam int               PW      = $clog2(CHANNELS + 1);
   localparam int               SW      = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CHANNELS-1:0] viol_next;
   logic [PW-1:0]       pop;
   logic [SW-1:0]       sum;
   logic [CNT_W-1:0]    cnt_nxt;

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
         dro_channel #(
            .SETUP_CYC (SETUP_CYC),
            .HOLD_CYC  (HOLD_CYC)
         ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .set        (set[i]),
            .reset      (reset),
            .clr        (clr),
            .mode_ndro  (mode_ndro),
            .out        (out[i]),
            .viol_setup (viol_setup[i]),
            .viol_hold  (viol_hold[i]),
            .viol_next  (viol_next[i])
         );
      end
   endgenerate

   // Setup and hold violations are mutually exclusive per channel, so each
   // violating channel contributes exactly one count.
   always_comb begin
      pop = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pop = pop + PW'(viol_next[i]);
      end
      sum     = SW'(viol_cnt) + SW'(pop);
      cnt_nxt = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         viol_cnt <= '0;
      end else begin
         viol_cnt <= cnt_nxt;
      end
   end

endmodule

`default_nettype wire
